// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared types and widths for the divider request sequencer.
//            - seq_state_t : sequencer FSM state encoding
//            - DIV_DIVIDEND_W / DIV_DIVISOR_W : native widths of the divider
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DIV_DIVIDEND_W = 64;
    localparam int DIV_DIVISOR_W  = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } seq_state_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_req_seq.sv
`default_nettype none
// ============================================================================
// Module   : div_req_seq
// Purpose  : Request sequencer around the iterative signed divider. Accepts
//            operands on a valid/ready request port, pulses the divider start
//            for one cycle, holds operands stable for the whole operation,
//            sticky-captures the divider's early overflow flag and its
//            one-cycle result, and returns a registered response on a
//            valid/ready port. A watchdog turns a silent divider into a
//            timeout response, then drains the divider before the next op.
// Ports    :
//   clk, reset_n                       clock / async active-low reset
//   req_valid/req_ready                request handshake
//   req_dividend/req_divisor/req_tag   request payload
//   div_valid_in                       one-cycle start pulse to divider
//   div_dividend/div_divisor           held operands to divider
//   div_quotient/div_remainder         divider results (with div_valid_out)
//   div_valid_out                      divider result strobe
//   div_overflow                       divider overflow (early pulse)
//   rsp_valid/rsp_ready                response handshake
//   rsp_quotient/rsp_remainder         captured results (0 on timeout)
//   rsp_overflow/rsp_timeout/rsp_tag   response status and tag
//   spurious_err                       sticky: unexpected result strobe
// Revision : 1.0 - initial release
// ============================================================================
module div_req_seq
    import div_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DIV_DIVIDEND_W,
    parameter int DIVISOR_WIDTH  = DIV_DIVISOR_W,
    parameter int TAG_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 127
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [DIVIDEND_WIDTH-1:0] req_dividend,
    input  logic [DIVISOR_WIDTH-1:0]  req_divisor,
    input  logic [TAG_WIDTH-1:0]      req_tag,
    output logic                      div_valid_in,
    output logic [DIVIDEND_WIDTH-1:0] div_dividend,
    output logic [DIVISOR_WIDTH-1:0]  div_divisor,
    input  logic [DIVIDEND_WIDTH-1:0] div_quotient,
    input  logic [DIVISOR_WIDTH-1:0]  div_remainder,
    input  logic                      div_valid_out,
    input  logic                      div_overflow,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DIVIDEND_WIDTH-1:0] rsp_quotient,
    output logic [DIVISOR_WIDTH-1:0]  rsp_remainder,
    output logic                      rsp_overflow,
    output logic                      rsp_timeout,
    output logic [TAG_WIDTH-1:0]      rsp_tag,
    output logic                      spurious_err
);

    localparam int                c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    seq_state_t                r_state;
    logic [DIVIDEND_WIDTH-1:0] r_dividend;
    logic [DIVISOR_WIDTH-1:0]  r_divisor;
    logic [TAG_WIDTH-1:0]      r_tag;
    logic [c_cnt_w-1:0]        r_cnt;
    logic                      r_ovf_seen;
    logic                      r_drain;
    logic [DIVIDEND_WIDTH-1:0] r_rsp_quotient;
    logic [DIVISOR_WIDTH-1:0]  r_rsp_remainder;
    logic                      r_rsp_overflow;
    logic                      r_rsp_timeout;
    logic [TAG_WIDTH-1:0]      r_rsp_tag;
    logic                      r_spurious;

    // A result strobe is only legitimate while the divider is known busy.
    logic w_strobe_unexpected;
    assign w_strobe_unexpected = div_valid_out &&
                                 ((r_state == IDLE) || (r_state == ISSUE) || (r_state == RESP));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= IDLE;
            r_dividend      <= '0;
            r_divisor       <= '0;
            r_tag           <= '0;
            r_cnt           <= '0;
            r_ovf_seen      <= 1'b0;
            r_drain         <= 1'b0;
            r_rsp_quotient  <= '0;
            r_rsp_remainder <= '0;
            r_rsp_overflow  <= 1'b0;
            r_rsp_timeout   <= 1'b0;
            r_rsp_tag       <= '0;
            r_spurious      <= 1'b0;
        end else begin
            if (w_strobe_unexpected) begin
                r_spurious <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_dividend <= req_dividend;
                        r_divisor  <= req_divisor;
                        r_tag      <= req_tag;
                        r_ovf_seen <= 1'b0;
                        r_state    <= ISSUE;
                    end
                end

                ISSUE: begin
                    // Overflow may already be flagged alongside the start pulse.
                    r_ovf_seen <= r_ovf_seen | div_overflow;
                    r_cnt      <= '0;
                    r_state    <= WAIT;
                end

                WAIT: begin
                    r_ovf_seen <= r_ovf_seen | div_overflow;
                    r_cnt      <= r_cnt + c_cnt_one;
                    // Result takes priority over a coincident watchdog expiry.
                    if (div_valid_out) begin
                        r_rsp_quotient  <= div_quotient;
                        r_rsp_remainder <= div_remainder;
                        r_rsp_overflow  <= r_ovf_seen | div_overflow;
                        r_rsp_timeout   <= 1'b0;
                        r_rsp_tag       <= r_tag;
                        r_state         <= RESP;
                    end else if (r_cnt == c_cnt_last) begin
                        r_rsp_quotient  <= '0;
                        r_rsp_remainder <= '0;
                        r_rsp_overflow  <= r_ovf_seen | div_overflow;
                        r_rsp_timeout   <= 1'b1;
                        r_rsp_tag       <= r_tag;
                        r_drain         <= 1'b1;
                        r_state         <= RESP;
                    end
                end

                RESP: begin
                    // Restart the watchdog so DRAIN gets a full window.
                    r_cnt <= '0;
                    if (rsp_ready) begin
                        r_state <= r_drain ? DRAIN : IDLE;
                    end
                end

                DRAIN: begin
                    // The divider may still be running on the held operands;
                    // wait for its late result (discarded) or a full window.
                    r_cnt <= r_cnt + c_cnt_one;
                    if (div_valid_out || (r_cnt == c_cnt_last)) begin
                        r_drain <= 1'b0;
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Handshake/strobe outputs are decoded straight from the state register.
    assign req_ready     = (r_state == IDLE);
    assign div_valid_in  = (r_state == ISSUE);
    assign rsp_valid     = (r_state == RESP);

    assign div_dividend  = r_dividend;
    assign div_divisor   = r_divisor;
    assign rsp_quotient  = r_rsp_quotient;
    assign rsp_remainder = r_rsp_remainder;
    assign rsp_overflow  = r_rsp_overflow;
    assign rsp_timeout   = r_rsp_timeout;
    assign rsp_tag       = r_rsp_tag;
    assign spurious_err  = r_spurious;

endmodule : div_req_seq
`default_nettype wire
